mem_port_arbiter: RTL

- Shares the single data-memory/cache port between the instruction-fetch requester (read-only) and the load/store requester (read/write).
- Uses valid/ready request handshakes, round-robin arbitration and one outstanding transaction.
- Counts a fixed memory latency, then returns a one-cycle response pulse to the winning requester.
- Sits between the core's fetch and LSU front ends and the memory unit's address, write_data, control, write_enable and read_en inputs.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
//   state_t     : transaction FSM states (IDLE -> BUSY -> RESP -> IDLE)
//   requester_t : which front end owns a grant (instruction fetch or load/store)
//   cnt_width() : width of the read-latency counter for a given latency
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } requester_t;

  // The counter holds values MEM_LATENCY-1 .. 0.
  function automatic int cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, rst          : clock, asynchronous active-high reset
//   req_if, req_d     : request lines from fetch and load/store
//   update            : a grant is being consumed this cycle; remember the winner
//   grant_if, grant_d : combinational one-hot (or zero) grant
// On a tie the requester that did not win last time is granted. After reset
// the data side counts as the last winner, so fetch wins the first tie.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_d,
  input  logic update,
  output logic grant_if,
  output logic grant_d
);

  requester_t last_grant;

  always_comb begin
    grant_if = req_if & (~req_d | (last_grant == REQ_D));
    grant_d  = req_d  & (~req_if | (last_grant == REQ_IF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_D;
    end else if (update) begin
      last_grant <= grant_if ? REQ_IF : REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch unit (read-only) and the LSU.
// One transaction is outstanding at a time: a request is accepted in IDLE,
// the memory port is driven in BUSY, and a one-cycle response pulse is
// returned to the winner in RESP.
//   clk, rst                         : clock, asynchronous active-high reset
//   if_req_valid/if_addr/if_req_ready: fetch request handshake
//   if_rsp_valid/if_rsp_data         : fetch response pulse and held data
//   d_req_valid/d_addr/d_wdata/d_we/d_ctrl/d_req_ready : load/store request
//   d_rsp_valid/d_rsp_data           : load/store completion pulse, load data
//   mem_*                            : memory unit interface
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         DATA_WIDTH    = 32,
  parameter int         ADDRESS_WIDTH = 32,
  parameter int         MEM_LATENCY   = 2,
  parameter logic [2:0] IF_CTRL       = 3'b010
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_req_ready,
  output logic                     if_rsp_valid,
  output logic [DATA_WIDTH-1:0]    if_rsp_data,
  input  logic                     d_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  input  logic                     d_we,
  input  logic [2:0]               d_ctrl,
  output logic                     d_req_ready,
  output logic                     d_rsp_valid,
  output logic [DATA_WIDTH-1:0]    d_rsp_data,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic [2:0]               mem_ctrl,
  output logic                     mem_write_enable,
  output logic                     mem_read_en,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  localparam int               CNT_W    = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t                   state, state_nxt;
  requester_t               owner;
  logic                     grant_if, grant_d;
  logic                     accept;
  logic                     busy_done;
  logic                     req_we;
  logic [CNT_W-1:0]         cnt;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic [2:0]               req_ctrl;
  logic [DATA_WIDTH-1:0]    if_data_q, d_data_q;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_if   (if_req_valid),
    .req_d    (d_req_valid),
    .update   (accept),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  assign accept    = (state == IDLE) & (grant_if | grant_d);
  // A store occupies the port for a single cycle; a read waits out the count.
  assign busy_done = req_we | (cnt == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (busy_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; ready is masked while reset is held so nothing is
  // advertised to the front ends during an asynchronous reset.
  always_comb begin
    if_req_ready     = 1'b0;
    d_req_ready      = 1'b0;
    if_rsp_valid     = 1'b0;
    d_rsp_valid      = 1'b0;
    mem_read_en      = 1'b0;
    mem_write_enable = 1'b0;
    case (state)
      IDLE: begin
        if_req_ready = grant_if & ~rst;
        d_req_ready  = grant_d & ~rst;
      end
      BUSY: begin
        mem_read_en      = ~req_we;
        mem_write_enable = req_we;
      end
      RESP: begin
        if_rsp_valid = (owner == REQ_IF);
        d_rsp_valid  = (owner == REQ_D);
      end
      default: ;
    endcase
  end

  // Request capture, latency count and read-data capture. Fetches leave the
  // store-data register untouched so mem_write_data keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= REQ_D;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_ctrl  <= '0;
      cnt       <= '0;
      if_data_q <= '0;
      d_data_q  <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
      if (grant_if) begin
        owner    <= REQ_IF;
        req_we   <= 1'b0;
        req_addr <= if_addr;
        req_ctrl <= IF_CTRL;
      end else begin
        owner     <= REQ_D;
        req_we    <= d_we;
        req_addr  <= d_addr;
        req_ctrl  <= d_ctrl;
        req_wdata <= d_wdata;
      end
    end else if ((state == BUSY) && !req_we) begin
      if (cnt == '0) begin
        if (owner == REQ_IF) begin
          if_data_q <= mem_read_data;
        end else begin
          d_data_q <= mem_read_data;
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign mem_address    = req_addr;
  assign mem_write_data = req_wdata;
  assign mem_ctrl       = req_ctrl;
  assign if_rsp_data    = if_data_q;
  assign d_rsp_data     = d_data_q;

endmodule
